// File: rtl/spirxdata.sv
// spirxdata: SD-card SPI block-read data phase; hunts the start token, packs data bytes into
// big-endian words for the block FIFO, then checks the trailing CRC-16 and reports a status byte.
module spirxdata #(
  parameter int DW = 32,
  parameter int AW = 8,
  parameter int TOKEN_TIMEOUT = 1023
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [3:0]    i_lgblksz,
  input  logic          i_fifo,
  output logic          o_busy,
  input  logic          i_ll_busy,
  output logic          o_ll_stb,
  output logic [7:0]    o_ll_byte,
  input  logic          i_ll_stb,
  input  logic [7:0]    i_ll_byte,
  output logic          o_write,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic          o_rxvalid,
  output logic [7:0]    o_response
);
  typedef enum logic [2:0] {IDLE, TOKEN, DATA, CRC, DRAIN, DONE} state_t;
  state_t      r_state;
  logic [1:0]  r_outst, w_outst_nx;
  logic [3:0]  r_lg;
  logic [9:0]  r_rem, r_cnt, r_tmo, w_n;
  logic [15:0] r_crc;
  logic [23:0] r_sr;
  logic [7:0]  r_crc_hi, r_status;
  logic        r_crc_second, w_accept, w_rx;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] x;
    x = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) x = x[15] ? {x[14:0], 1'b0} ^ 16'h1021 : {x[14:0], 1'b0};
    return x;
  endfunction

  // At most three requests may be in flight; after the token, requests stop once the
  // block plus its two CRC bytes have all been asked for.
  assign o_ll_byte  = 8'hFF;
  assign o_ll_stb   = (r_state == TOKEN || ((r_state == DATA || r_state == CRC) && r_rem != 10'd0)) && r_outst != 2'd3;
  assign w_accept   = o_ll_stb && !i_ll_busy;
  assign w_rx       = i_ll_stb && r_outst != 2'd0;
  assign w_outst_nx = r_outst + 2'(w_accept) - 2'(w_rx);
  assign w_n        = 10'd1 << r_lg;

  always_ff @(posedge i_clk)
    if (i_reset) begin
      r_state      <= IDLE;
      o_busy       <= 1'b0;
      o_write      <= 1'b0;
      o_rxvalid    <= 1'b0;
      o_response   <= 8'h00;
      o_addr       <= '0;
      o_data       <= '0;
      r_outst      <= 2'd0;
      r_lg         <= 4'd3;
      r_rem        <= 10'd0;
      r_cnt        <= 10'd0;
      r_tmo        <= 10'd0;
      r_crc        <= 16'h0000;
      r_sr         <= 24'h0;
      r_crc_hi     <= 8'h00;
      r_status     <= 8'h00;
      r_crc_second <= 1'b0;
    end else begin
      r_outst   <= w_outst_nx;
      o_write   <= 1'b0;
      o_rxvalid <= 1'b0;
      if (o_write) o_addr[AW-2:0] <= o_addr[AW-2:0] + 1'b1;
      if (w_accept && r_state != TOKEN) r_rem <= r_rem - 1'b1;
      case (r_state)
        IDLE, DONE:
          if (i_start) begin
            r_state      <= TOKEN;
            o_busy       <= 1'b1;
            o_addr       <= {i_fifo, {(AW-1){1'b0}}};
            r_lg         <= i_lgblksz < 4'd3 ? 4'd3 : i_lgblksz > 4'd9 ? 4'd9 : i_lgblksz;
            r_crc        <= 16'h0000;
            r_tmo        <= 10'(TOKEN_TIMEOUT);
            r_cnt        <= 10'd0;
            r_crc_second <= 1'b0;
          end else r_state <= IDLE;
        TOKEN:
          if (w_rx) begin
            if (i_ll_byte == 8'hFE) begin
              r_state <= DATA;
              r_rem   <= w_n + 10'd2 - 10'(w_outst_nx);
            end else if (i_ll_byte != 8'h00 && i_ll_byte < 8'h10) begin
              r_status <= i_ll_byte;
              r_state  <= DRAIN;
            end else begin
              r_tmo <= r_tmo - 1'b1;
              if (r_tmo == 10'd1) begin
                r_status <= 8'h20;
                r_state  <= DRAIN;
              end
            end
          end
        DATA:
          if (w_rx) begin
            r_sr  <= {r_sr[15:0], i_ll_byte};
            r_crc <= crc_byte(r_crc, i_ll_byte);
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt[1:0] == 2'd3) begin
              o_write <= 1'b1;
              o_data  <= {r_sr, i_ll_byte};
            end
            if (r_cnt == w_n - 1'b1) r_state <= CRC;
          end
        CRC:
          if (w_rx) begin
            r_crc_hi     <= i_ll_byte;
            r_crc_second <= 1'b1;
            if (r_crc_second) begin
              r_status <= {r_crc_hi, i_ll_byte} == r_crc ? 8'h00 : 8'h10;
              r_state  <= DRAIN;
            end
          end
        DRAIN:
          if (r_outst == 2'd0) begin
            r_state    <= DONE;
            o_rxvalid  <= 1'b1;
            o_response <= r_status;
            o_busy     <= 1'b0;
          end
        default: r_state <= IDLE;
      endcase
    end
endmodule
